// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling and a first-word-fall-through byte FIFO.
// Good bytes are pushed at the stop sample; framing errors and overflows pulse for one cycle.
module uart_rx_fifo #(
   parameter int clk_freq   = 50000000,
   parameter int baud       = 115200,
   parameter int depth_log2 = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       rd,
   output logic [7:0] drec,
   output logic       avail,
   output logic       full,
   output logic       ferr,
   output logic       ovf
);

   localparam int D     = clk_freq / baud;
   localparam int HALF  = D / 2;
   localparam int CW    = $clog2(D);
   localparam int AW    = depth_log2;
   localparam int PW    = depth_log2 + 1;
   localparam int DEPTH = 1 << depth_log2;

   localparam logic [CW-1:0] CNT_LAST = CW'(D - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   logic          rx_meta;
   logic          rxs;
   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [7:0]    shreg;

   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;

   logic stop_edge;
   logic push;
   logic pop;
   logic push_ok;

   assign stop_edge = (state == STOP) && (cnt == CNT_LAST);
   assign push      = stop_edge && rxs;
   assign pop       = rd && avail;
   // A pop in the same cycle frees the head slot, so a push into a full FIFO still fits.
   assign push_ok   = push && (!full || pop);

   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= rx;
         rxs     <= rx_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         shreg <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!rxs) begin
                  state <= START;
                  cnt   <= '0;
               end
            end
            START: begin
               cnt <= cnt + CW'(1);
               if (cnt == CNT_HALF) begin
                  cnt <= '0;
                  idx <= '0;
                  state <= rxs ? IDLE : DATA;
               end
            end
            DATA: begin
               cnt <= cnt + CW'(1);
               if (cnt == CNT_LAST) begin
                  cnt   <= '0;
                  shreg <= {rxs, shreg[7:1]};
                  if (idx == 3'd7) state <= STOP;
                  else             idx   <= idx + 3'd1;
               end
            end
            STOP: begin
               cnt <= cnt + CW'(1);
               if (cnt == CNT_LAST) begin
                  cnt   <= '0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ferr <= 1'b0;
         ovf  <= 1'b0;
      end else begin
         ferr <= stop_edge && !rxs;
         ovf  <= push && full && !rd;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push_ok) wptr <= wptr + PW'(1);
         if (pop)     rptr <= rptr + PW'(1);
      end
   end

   // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wptr[AW-1:0]] <= shreg;
   end

   assign avail = (wptr != rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign drec  = avail ? mem[rptr[AW-1:0]] : 8'h00;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial receive half of the UART. It oversamples the asynchronous `rx` line with a clock-derived bit timer and deframes 8N1 characters (1 start, 8 data LSB-first, 1 stop). Each good byte is pushed into a small first-word-fall-through FIFO that the system core drains with `rd`/`drec`. It sits beside the existing `denv`/`wr` transmit path inside `system`, and it is the receiver for the same line format.

## Interface

- `clk_freq`, 50000000, system clock frequency in Hz.
- `baud`, 115200, line rate in bit/s. Bit period D = clk_freq/baud (integer division); HALF = D/2. D ≥ 4 is required.
- `depth_log2`, 2, FIFO depth = 2^depth_log2 bytes.

Ports:

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `rx`  in  1  asynchronous serial input; idles high.
- `rd`  in  1  pop strobe; one byte is consumed per cycle that `rd`=1 and `avail`=1.
- `drec`  out  8  FIFO head byte; valid while `avail`=1.
- `avail`  out  1  FIFO not empty.
- `full`  out  1  FIFO holds 2^depth_log2 bytes.
- `ferr`  out  1  one-cycle pulse: stop bit sampled low, byte discarded.
- `ovf`  out  1  one-cycle pulse: good byte arrived while FIFO full with no same-cycle pop; byte discarded.

## Operation

- Input sync: two flops, both reset to 1. The FSM sees only the synchronized `rxs`.
- Bit counter `cnt` has width clog2(D). Bit index `idx` is 0..7. The data shift register shifts right, and the new bit enters at [7].
- FSM states:
  - IDLE: when `rxs`=0, go to START and set `cnt`=0.
  - START: increment `cnt`. When `cnt`=HALF-1, sample `rxs`. If `rxs`=0, go to DATA with `cnt`=0, `idx`=0. If `rxs`=1 (glitch), return to IDLE with no output.
  - DATA: increment `cnt`. When `cnt`=D-1, sample `rxs` into the shift register and set `cnt`=0. After `idx`=7, go to STOP; otherwise increment `idx`.
  - STOP: increment `cnt`. When `cnt`=D-1, sample `rxs`, then return to IDLE in the same cycle.
    - `rxs`=1: push the byte.
    - `rxs`=0: pulse `ferr`; no push.
- FIFO: circular buffer with read and write pointers of depth_log2+1 bits, so full and empty are distinguished by the MSB. Pointers wrap modulo 2^depth_log2.
  - `drec` = mem[rdptr] and is combinational from the registered state.
  - Push when not full: write the byte.
  - Push when full and `rd`=1 in the same cycle: accept the push. The pop frees the slot and the occupancy is unchanged.
  - Push when full and `rd`=0: drop the byte and pulse `ovf`.
  - `rd` when empty is ignored. Pointers are unchanged and no error is raised.
  - Simultaneous push and pop when the FIFO is neither empty nor full: both take effect and the occupancy is unchanged.
  - Pop and push together when empty cannot occur, because a pop needs `avail`=1.
- Resynchronisation: a new start bit is detected in IDLE at the earliest on the cycle after the stop sample, which is mid stop bit.

## Timing

- Reset (`rst`=0 at an edge):
  - FSM goes to IDLE; `cnt`, `idx` and the shift register clear to 0.
  - Pointers clear, so the FIFO is empty.
  - Outputs: `drec`=0 (memory content is don't-care, but `drec` is forced to 0 while empty), `avail`=0, `full`=0, `ferr`=0, `ovf`=0.
  - Reset mid-frame discards the partial byte and all stored bytes.
- Sample points, counted from cycle T0 (the first START cycle, one cycle after IDLE sees `rxs`=0):
  - start bit at T0+HALF-1;
  - data bit k at T0+HALF-1+(k+1)·D;
  - stop bit at T0+HALF-1+9·D.
- `rx`-to-`rxs` latency is 2 cycles.
- Push occurs at the stop-sample edge, so `avail`=1 on the following cycle.
- `ferr` and `ovf` are high for exactly the cycle after the stop-sample edge.
- Pop: the pointer advances at the edge where `rd`=1 and `avail`=1. The next byte appears on `drec` in the following cycle, and `avail` drops then if the FIFO is now empty.
- Throughput: back-to-back frames at nominal baud are received with no lost bytes as long as the consumer pops at least once per 10·D cycles.

## Test plan

All scenarios use bench parameters tck=20 ns, clk_freq=50000000, baud=3125000, giving D=16 and HALF=8, with depth_log2=2.

- Reset: hold `rst`=0 for 4 cycles with `rx`=1, then release. Required: `avail`=`full`=`ferr`=`ovf`=0 and `drec`=0, and they stay so with `rx` idle.
- Single byte: send 0x05 as an 8N1 frame at 16 clk/bit. Required:
  - `avail` rises the cycle after the stop sample;
  - `drec`=0x05;
  - one `rd` pulse drops `avail` the next cycle.
- Order and wrap: send 0x05, 0x0A, 0x0F, 0xFF back-to-back. Required: `full`=1 after the fourth byte. Then pop 4 times and send 0xA5, 0x3C. Required:
  - the first four pops read 0x05, 0x0A, 0x0F, 0xFF;
  - the next two pops read 0xA5, 0x3C, confirming pointer wrap.
- Overflow and simultaneous push/pop:
  - Fill the FIFO and send 0x77 with `rd`=0. Required: `ovf` pulses for one cycle and the contents are unchanged.
  - Refill to full and send 0x88 with `rd`=1 exactly on the stop-sample cycle. Required: no `ovf`, `full` stays 1, and 0x88 is the last byte read.
- Framing and glitch:
  - Send a frame with stop bit 0. Required: `ferr` pulses once and nothing is pushed.
  - Send a 4-cycle low glitch on `rx`. Required: the FSM returns to IDLE and there is no push and no `ferr`.
- Reset mid-frame: assert `rst` during data bit 3 while 2 bytes are stored, then release and send 0x5A. Required: the FIFO is empty after reset, and only 0x5A is received afterward.
